// File: rtl/leg_fetch_pkg.sv
// Shared types and helpers for the instruction prefetch buffer and its FIFO.
package leg_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; clear wins over push and pop.
module fetch_fifo
  import leg_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          clear,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  fetch_entry_t  mem_r [DEPTH];
  logic          pop_s;
  logic          push_s;

  assign empty  = (count_r == {CW{1'b0}});
  assign full   = (count_r == CW'(DEPTH));
  assign pop_s  = pop && !empty;
  assign push_s = push && (!full || pop_s);
  assign head   = mem_r[rd_ptr_r];
  assign count  = count_r;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  fetch_fifo_checker u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop_s),
    .clear (clear),
    .full  (full)
  );

endmodule

// File: rtl/fetch_fifo_checker.sv
// Protocol checker for fetch_fifo: a push into a full FIFO must come with a pop.
module fetch_fifo_checker (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic pop,
  input logic clear,
  input logic full
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !clear));

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Fetch-side prefetch queue: runs ahead issuing sequential word fetches,
// buffers {PC, instruction} pairs and flushes on redirect.
module instr_prefetch_buffer
  import leg_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        IReq,
  output logic [31:0] IAddr,
  input  logic        IAck,
  input  logic [31:0] IRData,
  input  logic        RedirectF,
  input  logic [31:0] RedirectPC,
  input  logic        StallF,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic        InstrValidF,
  output logic        Full
);

  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t  state_r, state_s;
  logic [31:0]   pref_pc_r, pref_pc_s;
  logic [31:0]   disc_addr_r, disc_addr_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] count_s;
  logic [CW-1:0] count_after_pop_s;
  logic          empty_s;
  logic          full_s;
  fetch_entry_t  head_s;
  fetch_entry_t  push_data_s;

  assign pop_s             = !empty_s && !StallF && !RedirectF;
  assign count_after_pop_s = count_s - {{(CW-1){1'b0}}, pop_s};
  assign push_data_s       = '{pc: pref_pc_r, instr: IRData};

  // Next state, next fetch PC and push decision
  always_comb begin
    state_s     = state_r;
    pref_pc_s   = pref_pc_r;
    disc_addr_s = disc_addr_r;
    push_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (RedirectF) begin
          pref_pc_s = align_word(RedirectPC);
        end else if (count_after_pop_s < DEPTH_C) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (RedirectF) begin
          pref_pc_s = align_word(RedirectPC);
          if (IAck) begin
            state_s = IDLE;
          end else begin
            state_s     = DISCARD;
            disc_addr_s = pref_pc_r;
          end
        end else if (IAck) begin
          push_s    = 1'b1;
          pref_pc_s = pref_pc_r + 32'd4;
          // The pushed word takes one slot; keep going only if another is free.
          state_s   = (count_after_pop_s < (DEPTH_C - CW'(1))) ? REQ : IDLE;
        end else begin
          state_s = REQ;
        end
      end
      DISCARD: begin
        if (RedirectF) begin
          pref_pc_s = align_word(RedirectPC);
        end else begin
          pref_pc_s = pref_pc_r;
        end
        if (IAck) begin
          state_s = IDLE;
        end else begin
          state_s = DISCARD;
        end
      end
      default: begin
        state_s   = IDLE;
        pref_pc_s = RESET_PC;
      end
    endcase
  end

  // Fetch state, prefetch PC and stale-request address registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      pref_pc_r   <= RESET_PC;
      disc_addr_r <= RESET_PC;
    end else begin
      state_r     <= state_s;
      pref_pc_r   <= pref_pc_s;
      disc_addr_r <= disc_addr_s;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .clear     (RedirectF),
    .head      (head_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign IReq        = (state_r == REQ) || (state_r == DISCARD);
  assign IAddr       = (state_r == DISCARD) ? disc_addr_r : pref_pc_r;
  assign InstrValidF = !empty_s;
  assign InstrF      = empty_s ? 32'h0000_0000 : head_s.instr;
  assign PCF         = empty_s ? 32'h0000_0000 : head_s.pc;
  assign Full        = full_s;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Self-checking bench for instr_prefetch_buffer: queue-based reference model
// compared every cycle, plus hand-computed checkpoints.
module tb_instr_prefetch_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        IReq;
  logic [31:0] IAddr;
  logic        IAck = 1'b0;
  logic [31:0] IRData = 32'h0;
  logic        RedirectF = 1'b0;
  logic [31:0] RedirectPC = 32'h0;
  logic        StallF = 1'b0;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic        InstrValidF;
  logic        Full;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .IReq        (IReq),
    .IAddr       (IAddr),
    .IAck        (IAck),
    .IRData      (IRData),
    .RedirectF   (RedirectF),
    .RedirectPC  (RedirectPC),
    .StallF      (StallF),
    .InstrF      (InstrF),
    .PCF         (PCF),
    .InstrValidF (InstrValidF),
    .Full        (Full)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of fetched words, one outstanding request at most
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_addr = 32'h0;
  bit          m_out = 1'b0;
  bit          m_stale = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_pc = 32'h0; m_addr = 32'h0; m_out = 1'b0; m_stale = 1'b0;
    end else begin
      bit ack;
      ack = IAck && m_out;
      if (RedirectF) begin
        mq.delete();
        m_pc = RedirectPC & 32'hFFFF_FFFC;
        if (m_out && !ack) m_stale = 1'b1;
        else m_out = 1'b0;
      end else begin
        if (mq.size() > 0 && !StallF) void'(mq.pop_front());
        if (ack) begin
          m_out = 1'b0;
          if (!m_stale) begin
            mq.push_back('{m_addr, IRData});
            m_pc = m_addr + 32'd4;
            if (mq.size() < DEPTH) begin
              m_out = 1'b1; m_addr = m_pc;
            end
          end
          m_stale = 1'b0;
        end else if (!m_out && mq.size() < DEPTH) begin
          m_out = 1'b1; m_addr = m_pc; m_stale = 1'b0;
        end
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] e_addr;
      e_addr = m_out ? m_addr : m_pc;
      check("m_IReq", {31'b0, IReq}, {31'b0, m_out});
      check("m_IAddr", IAddr, e_addr);
      check("m_InstrValidF", {31'b0, InstrValidF}, {31'b0, mq.size() > 0});
      check("m_Full", {31'b0, Full}, {31'b0, mq.size() == DEPTH});
      check("m_PCF", PCF, (mq.size() > 0) ? mq[0].pc : 32'h0);
      check("m_InstrF", InstrF, (mq.size() > 0) ? mq[0].instr : 32'h0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      IRData = mem_word(IAddr);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk_en = 1'b1;
    cyc(2);
    check("rst_IReq", {31'b0, IReq}, 32'h0);
    check("rst_IAddr", IAddr, 32'h0);
    check("rst_Valid", {31'b0, InstrValidF}, 32'h0);
    check("rst_Full", {31'b0, Full}, 32'h0);
    check("rst_InstrF", InstrF, 32'h0);
    check("rst_PCF", PCF, 32'h0);

    // Streaming with acks every cycle
    IAck = 1'b1; reset = 1'b1;
    cyc(1);
    check("s_IReq", {31'b0, IReq}, 32'h1);
    check("s_IAddr0", IAddr, 32'h0);
    cyc(1);
    check("s_PCF0", PCF, 32'h0);
    check("s_InstrF0", InstrF, 32'hDEAD_BEEF);
    check("s_IAddr4", IAddr, 32'h4);
    cyc(1);
    check("s_PCF4", PCF, 32'h4);
    check("s_IAddr8", IAddr, 32'h8);
    cyc(6);

    // Fill to full under stall, then drain in order
    StallF = 1'b1; reset = 1'b0; cyc(1); reset = 1'b1;
    cyc(8);
    check("f_Full", {31'b0, Full}, 32'h1);
    check("f_IReq", {31'b0, IReq}, 32'h0);
    check("f_PCF", PCF, 32'h0);
    StallF = 1'b0;
    cyc(1);
    check("f_PCF4", PCF, 32'h4);
    check("f_Full0", {31'b0, Full}, 32'h0);
    check("f_IReq1", {31'b0, IReq}, 32'h1);
    check("f_IAddr10", IAddr, 32'h10);
    cyc(1); check("f_PCF8", PCF, 32'h8);
    cyc(1); check("f_PCFC", PCF, 32'hC);
    cyc(1); check("f_PCF10", PCF, 32'h10);

    // Redirect while a request waits for its ack
    IAck = 1'b0; reset = 1'b0; cyc(1); reset = 1'b1;
    cyc(1);
    check("d_IAddr0", IAddr, 32'h0);
    RedirectF = 1'b1; RedirectPC = 32'h100;
    cyc(1);
    check("d_IReq", {31'b0, IReq}, 32'h1);
    check("d_IAddrOld", IAddr, 32'h0);
    RedirectF = 1'b0;
    cyc(1);
    check("d_IAddrHold", IAddr, 32'h0);
    IAck = 1'b1;
    cyc(1);
    check("d_IReq0", {31'b0, IReq}, 32'h0);
    check("d_Valid0", {31'b0, InstrValidF}, 32'h0);
    cyc(1);
    check("d_IAddr100", IAddr, 32'h100);
    cyc(1);
    check("d_PCF100", PCF, 32'h100);
    check("d_InstrF100", InstrF, 32'hDFAD_BEEF);

    // Redirect coinciding with ack and pop
    RedirectF = 1'b1; RedirectPC = 32'h200;
    cyc(1);
    check("r_Valid0", {31'b0, InstrValidF}, 32'h0);
    check("r_IAddr200", IAddr, 32'h200);
    RedirectF = 1'b0;
    cyc(1);
    check("r_IReq", {31'b0, IReq}, 32'h1);
    cyc(1);
    check("r_PCF200", PCF, 32'h200);

    // Alignment and wrap
    RedirectF = 1'b1; RedirectPC = 32'hFFFF_FFFE;
    cyc(1);
    RedirectF = 1'b0;
    cyc(1);
    check("w_IAddrFFC", IAddr, 32'hFFFF_FFFC);
    cyc(1);
    check("w_IAddr0", IAddr, 32'h0);
    check("w_PCF", PCF, 32'hFFFF_FFFC);

    // Asynchronous reset mid-request with two entries queued
    StallF = 1'b1;
    cyc(1);
    check("x_Valid", {31'b0, InstrValidF}, 32'h1);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check("x_IReq0", {31'b0, IReq}, 32'h0);
    check("x_Valid0", {31'b0, InstrValidF}, 32'h0);
    check("x_IAddr", IAddr, 32'h0);
    cyc(1);
    reset = 1'b1; StallF = 1'b0;
    cyc(1);
    check("x_IAddrRst", IAddr, 32'h0);
    check("x_IReqRst", {31'b0, IReq}, 32'h1);

    // Mixed ack/stall/redirect pattern, model-checked
    for (int i = 0; i < 48; i++) begin
      IAck      = ((i * 7) % 3) != 0;
      StallF    = ((i % 5) == 1) || ((i % 5) == 2) || ((i % 11) == 4);
      RedirectF = (i == 20) || (i == 33);
      RedirectPC = (i == 20) ? 32'h0000_3000 : 32'h0000_4002;
      cyc(1);
    end
    RedirectF = 1'b0;
    cyc(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
